// File: rtl/mips_ex_bjp_resolve_pkg.sv
// Shared MIPS core widths and the decode-info bit positions of the
// conditional-branch (BJP) group consumed by the EX branch resolver.
package mips_ex_bjp_resolve_pkg;

  localparam int MIPS_ADDR_WIDTH = 32;
  localparam int MIPS_DATA_WIDTH = 32;

  // Positions of the conditional-branch decode bits inside DECINFO.
  localparam int DECINFO_BJP_BGEZ = 0;
  localparam int DECINFO_BJP_BLTZ = 1;
  localparam int DECINFO_BJP_BEQ  = 2;
  localparam int DECINFO_BJP_BNE  = 3;
  localparam int DECINFO_BJP_BLEZ = 4;
  localparam int DECINFO_BJP_BGTZ = 5;
  localparam int DECINFO_BJP_W    = 6;

  // The ex_bjp input of the resolver is the OR of the branch decode bits.
  function automatic logic decinfo_is_bjp(input logic [DECINFO_BJP_W-1:0] bjp_bits);
    return |bjp_bits;
  endfunction

endpackage

// File: rtl/mips_perf_sat_cnt.sv
// Saturating event counter: clear wins over increment, holds at all-ones.
module mips_perf_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] sat
);

  // Count events; stop at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      sat <= '0;
    end else if (inc && (sat != '1)) begin
      sat <= sat + 1'b1;
    end
  end

endmodule

// File: rtl/mips_ex_bjp_resolve.sv
// EX-stage conditional branch resolver: turns a taken ALU compare into a
// registered PC redirect towards IF, kills the wrong-path IF/ID slots while
// the redirect is pending, and counts resolved/taken branches.
module mips_ex_bjp_resolve
  import mips_ex_bjp_resolve_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_WIDTH,
  parameter int DATA_W = MIPS_DATA_WIDTH,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_bjp,
  input  logic              bjp_cmp_res,
  input  logic [DATA_W-1:0] bjp_imm,
  input  logic [ADDR_W-1:0] bjp_pc_incr,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              ifid_flush,
  output logic              if_hold,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_br_cnt,
  output logic [CNT_W-1:0]  perf_tkn_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state;
  logic                resolve;
  logic                taken;
  logic signed [DATA_W-1:0] imm_s;
  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   target;
  logic                cnt_clr;

  // A branch is only honoured in IDLE; in WAIT the instruction in EX is
  // already on the flushed wrong path.
  assign resolve = ex_valid & ex_bjp & (state == S_IDLE);
  assign taken   = resolve & bjp_cmp_res;

  // Offset is in words; sign-extend (or truncate) to the PC width, then
  // scale to bytes. Carry out of the PC width is deliberately dropped.
  assign imm_s  = bjp_imm;
  assign offset = ADDR_W'(imm_s) << 2;
  assign target = bjp_pc_incr + offset;

  // Flush is combinational so the resolve cycle itself already kills ID.
  assign ifid_flush = ~rst & (taken | (state == S_WAIT));

  // Redirect FSM: latch target on a taken branch, hold until IF accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      if_hold        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (taken) begin
            state          <= S_WAIT;
            redirect_valid <= 1'b1;
            if_hold        <= 1'b1;
            redirect_pc    <= target;
          end
        end
        S_WAIT: begin
          if (redirect_ready) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            if_hold        <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          if_hold        <= 1'b0;
        end
      endcase
    end
  end

  // A branch reaching EX while a redirect is pending means the flush failed.
  assert property (@(posedge clk) disable iff (rst)
                   !((state == S_WAIT) && ex_valid && ex_bjp));

  // Reset clears the counters alongside the explicit software clear.
  assign cnt_clr = rst | perf_clr;

  mips_perf_sat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (resolve),
    .sat (perf_br_cnt)
  );

  mips_perf_sat_cnt #(.CNT_W(CNT_W)) u_tkn_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (taken),
    .sat (perf_tkn_cnt)
  );

endmodule

// File: doc/mips_ex_bjp_resolve.md
Name: mips_ex_bjp_resolve

Overview:
Consumer side of the shared ALU branch-compare datapath. It takes the ALU compare result for a conditional branch in EX, computes the branch target, and issues a registered PC redirect to IF over a valid/ready handshake. While that redirect is pending it kills wrong-path instructions in IF/ID. It also keeps saturating branch/taken performance counters.

Parameters:
ADDR_W, `MIPS_ADDR_WIDTH, width of PC/target.
DATA_W, `MIPS_DATA_WIDTH, width of immediate.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
ex_valid  input  1  EX holds a valid instruction this cycle
ex_bjp  input  1  EX instruction is a conditional branch (OR of BGEZ/BLTZ/BEQ/BNE/BLEZ/BGTZ decode bits)
bjp_cmp_res  input  1  ALU compare result for the requested condition; 1 = taken
bjp_imm  input  DATA_W  sign-extended branch offset, in words
bjp_pc_incr  input  ADDR_W  PC+4 of the branch
redirect_valid  output  1  redirect request to IF
redirect_pc  output  ADDR_W  redirect target
redirect_ready  input  1  IF accepts the redirect
ifid_flush  output  1  kill the instruction in ID and the one entering ID
if_hold  output  1  freeze PC update in IF
perf_clr  input  1  synchronous clear of the performance counters
perf_br_cnt  output  CNT_W  number of branches resolved
perf_tkn_cnt  output  CNT_W  number of branches taken

Behaviour:
- Reset: state IDLE; redirect_valid=0; redirect_pc=0; if_hold=0; perf_br_cnt=0; perf_tkn_cnt=0. ifid_flush=0 while rst is high.
- resolve = ex_valid & ex_bjp (only sampled in IDLE); taken = resolve & bjp_cmp_res.
- Target = bjp_pc_incr + (bjp_imm << 2), truncated to ADDR_W; wrap-around is ignored.
- FSM has two states, IDLE and WAIT.
- IDLE, taken:
  - latch the target into redirect_pc;
  - next cycle: state=WAIT, redirect_valid=1, if_hold=1;
  - ifid_flush is driven combinationally high in the resolve cycle.
- IDLE, not taken: no state change and no flush.
- WAIT:
  - redirect_valid=1 and if_hold=1;
  - ifid_flush=1 every cycle;
  - redirect_pc is held stable until accepted.
- WAIT with redirect_ready=1 (transfer): next cycle state=IDLE, redirect_valid=0, if_hold=0. Minimum redirect latency is resolve+1 cycle; each ready-low cycle adds one.
- Branch in EX while in WAIT: illegal, because ID is flushed. It is ignored (no counting, no latch) and flagged by a simulation assertion.
- redirect_ready while in IDLE: ignored.
- Counters:
  - perf_br_cnt increments on resolve; perf_tkn_cnt increments on taken.
  - Both saturate at all-ones.
  - perf_clr has priority over increment, and a clear and an increment in the same cycle yields 0.
- rst in WAIT: immediate return to IDLE; the pending redirect is dropped and redirect_valid goes to 0 the next cycle.

Decomposition:
- mips_defines holds ADDR/DATA width macros and the DECINFO BJP bit indices.
- IDLE/WAIT state encoding is a localparam in the module.
- One sub-module, mips_perf_sat_cnt (width param, inc, clr, sat output), instantiated twice.

Test Plan:
- Reset then idle: with rst held 3 cycles, all outputs are 0; after release, with no branch, they stay 0.
- BEQ taken with redirect_ready=1: pc_incr=0x0000_1004, imm=0x0000_0003 gives ifid_flush=1 in the resolve cycle. Next cycle redirect_valid=1 with redirect_pc=0x0000_1010, accepted, and redirect_valid=0 the cycle after. Counters read 1/1.
- Negative offset with ready stalled: pc_incr=0x0000_2000, imm=0xFFFF_FFFE gives redirect_pc=0x0000_1FF8. With ready low for 3 cycles, redirect_valid, if_hold, ifid_flush and redirect_pc stay stable for 4 cycles and drop after acceptance.
- Not taken: bjp_cmp_res=0 gives no redirect and no flush; perf_br_cnt increments and perf_tkn_cnt does not.
- Reset mid-WAIT: rst is asserted on the second WAIT cycle. redirect_valid=0 the next cycle, the FSM is in IDLE, and a following taken branch redirects normally.
- Counter boundary: with CNT_W=4, 16 taken branches leave both counters at 0xF. perf_clr together with a resolve gives 0 the next cycle.
